cpu_core: RTL and testbench

Multi-cycle 32-bit load/store processor core for the FPGA top level. It drives a single shared address/data bus to a synchronous word RAM at 0x0000_0000–0x0000_0FFF. The top level also captures any store to address 0 into its debug register. Execution starts at PC 0 out of RAM after reset.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/cpu_alu.sv | 30 +++
 rtl/cpu_core.sv | 119 +++++++++++
 tb/tb_cpu_core.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle cpu_core: opcodes, FSM states,
// instruction field positions. CPU_MUL_EN enables the MUL opcode.
package cpu_pkg;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_XOR  = 6'h05;
  localparam logic [5:0] OP_SHL  = 6'h06;
  localparam logic [5:0] OP_SHR  = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_MOVH = 6'h09;
  localparam logic [5:0] OP_ORI  = 6'h0A;
  localparam logic [5:0] OP_LD   = 6'h0B;
  localparam logic [5:0] OP_ST   = 6'h0C;
  localparam logic [5:0] OP_BEQ  = 6'h0D;
  localparam logic [5:0] OP_BNE  = 6'h0E;
  localparam logic [5:0] OP_JMPL = 6'h0F;
  localparam logic [5:0] OP_MUL  = 6'h10;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 6;
  localparam int RS1_LSB = 11;
  localparam int RS2_LSB = 16;
  localparam int IMM_LSB = 16;

  typedef enum logic [2:0] {
    FETCH,
    IRWAIT,
    EXEC,
    MEM,
    LDWAIT
  } state_t;

  // Opcodes that write rd at the end of EXEC.
  function automatic logic writes_rd(input logic [5:0] op);
    logic w;
    w = (op >= OP_ADD && op <= OP_ORI) || (op == OP_JMPL);
`ifdef CPU_MUL_EN
    w = w || (op == OP_MUL);
`endif
    return w;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: op, a, b -> y. Address adds (LD/ST/JMPL) use ADD.
// MUL is only built when CPU_MUL_EN is defined.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  always_comb begin
    y = a + b;
    case (op)
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SHL:  y = a << b[4:0];
      OP_SHR:  y = a >> b[4:0];
      OP_MOVH: y = {b[15:0], 16'h0000};
      OP_ORI:  y = a | b;
`ifdef CPU_MUL_EN
      OP_MUL:  y = a * b;
`endif
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle 32-bit load/store core on one shared word-RAM bus.
// Ports: clk, reset (async high), data_in, data_out, write, address.
// CPU_MUL_EN adds the MUL opcode (completes in EXEC).
module cpu_core
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        write,
  output logic [31:0] address
);

  state_t      state, state_nx;
  logic [31:0] pc, ir;
  logic [31:0] gpr [32];

  logic [5:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [15:0] imm;
  logic [31:0] rd_v, rs1_v, rs2_v;
  logic [31:0] sext, zext, opb;
  logic [31:0] alu_y, pc_inc;
  logic        taken, is_mem;

  assign op   = ir[OPC_LSB +: 6];
  assign rd   = ir[RD_LSB +: 5];
  assign rs1  = ir[RS1_LSB +: 5];
  assign rs2  = ir[RS2_LSB +: 5];
  assign imm  = ir[IMM_LSB +: 16];

  // gpr[0] is never written, so it always reads 0.
  assign rd_v  = gpr[rd];
  assign rs1_v = gpr[rs1];
  assign rs2_v = gpr[rs2];

  assign sext   = {{16{imm[15]}}, imm};
  assign zext   = {16'h0000, imm};
  assign pc_inc = pc + 32'd4;
  assign is_mem = (op == OP_LD) || (op == OP_ST);

  assign taken = ((op == OP_BEQ) && (rd_v == rs1_v)) ||
                 ((op == OP_BNE) && (rd_v != rs1_v));

  always_comb begin
    opb = sext;
    if (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                   OP_SHL, OP_SHR, OP_MUL})
      opb = rs2_v;
    else if (op == OP_ORI || op == OP_MOVH)
      opb = zext;
  end

  cpu_alu u_alu (
    .op (op),
    .a  (rs1_v),
    .b  (opb),
    .y  (alu_y)
  );

  // In MEM the ALU output is the effective address rs1 + sext.
  always_comb begin
    state_nx = state;
    address  = pc;
    write    = 1'b0;
    unique case (state)
      FETCH:  state_nx = IRWAIT;
      IRWAIT: state_nx = EXEC;
      EXEC:   state_nx = is_mem ? MEM : FETCH;
      MEM: begin
        address  = alu_y;
        write    = (op == OP_ST);
        state_nx = (op == OP_LD) ? LDWAIT : FETCH;
      end
      LDWAIT: state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= '0;
      ir       <= '0;
      data_out <= '0;
    end else begin
      if (state == IRWAIT)
        ir <= data_in;
      if (state == EXEC) begin
        if (op == OP_ST)
          data_out <= rd_v;
        if (op == OP_JMPL)
          pc <= alu_y;
        else if (taken)
          pc <= pc_inc + {sext[29:0], 2'b00};
        else
          pc <= pc_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        gpr[i] <= '0;
    end else if (rd != 5'd0) begin
      if (state == EXEC && writes_rd(op))
        gpr[rd] <= (op == OP_JMPL) ? pc_inc : alu_y;
      else if (state == LDWAIT)
        gpr[rd] <= data_in;
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: directed programs plus randomized
// programs compared against an instruction-level reference model.
module tb_cpu_core;

  localparam int NOP = 0, ADD = 1, SUB = 2, AND_ = 3, OR_ = 4, XOR_ = 5;
  localparam int SHL = 6, SHR = 7, ADDI = 8, MOVH = 9, ORI = 10;
  localparam int LD = 11, ST = 12, BEQ = 13, BNE = 14, JMPL = 15;
  localparam int MUL = 16;

  logic        clk = 0;
  logic        reset = 1;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        write;
  logic [31:0] address;

  cpu_core dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .write    (write),
    .address  (address)
  );

  always #5 clk = ~clk;

  logic [31:0] prog [1024];
  logic [31:0] mem  [1024];
  logic [31:0] rdata;
  int          pp;

  // Synchronous RAM; program image reloaded while reset is held.
  always @(posedge clk) begin
    rdata <= mem[address[11:2]];
    if (reset)
      mem <= prog;
    else if (write && address[1:0] == 2'b00 && address < 32'h1000)
      mem[address[11:2]] <= data_out;
  end
  assign data_in = rdata;

  int          cyc;
  int          nwr;
  logic [31:0] addr_log [4096];
  logic [31:0] got_d [$];
  int          got_c [$];

  always @(negedge clk) begin
    if (reset) begin
      cyc = 0;
      nwr = 0;
      got_d.delete();
      got_c.delete();
    end else begin
      if (cyc < 4096) addr_log[cyc] = address;
      if (write) begin
        nwr++;
        if (address == 32'h0) begin
          got_d.push_back(data_out);
          got_c.push_back(cyc);
        end
      end
      cyc++;
    end
  end

  int n_pass = 0;
  int n_chk  = 0;

  function automatic logic [31:0] enc_r(int op, int rd, int rs1, int rs2);
    return {11'b0, rs2[4:0], rs1[4:0], rd[4:0], op[5:0]};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rd, int rs1,
                                        logic [15:0] imm);
    return {imm, rs1[4:0], rd[4:0], op[5:0]};
  endfunction

  logic [31:0] halt_w;
  assign halt_w = {16'hFFFF, 5'd0, 5'd0, 6'd13};

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) prog[i] = 32'h0;
    pp = 0;
  endtask

  task automatic emit(input logic [31:0] w);
    prog[pp] = w;
    pp++;
  endtask

  task automatic run(input int ncyc);
    reset = 1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 0;
    repeat (ncyc) @(negedge clk);
    #1;
  endtask

  // Instruction-level model: expected stores to address 0 and their
  // MEM cycle, from per-class cycle costs (ALU 3, ST 4, LD 5).
  logic [31:0] exp_d [$];
  int          exp_c [$];
  int          end_cyc;

  task automatic iss();
    logic [31:0] mm [1024];
    logic [31:0] r [32];
    logic [31:0] pc, ins, a, b, d, se, ze, ea, res, npc;
    int op, rd, rs1, rs2, cost;
    logic wrt;
    for (int i = 0; i < 1024; i++) mm[i] = prog[i];
    for (int i = 0; i < 32; i++) r[i] = 0;
    exp_d.delete();
    exp_c.delete();
    pc = 0;
    end_cyc = 0;
    for (int n = 0; n < 3000; n++) begin
      ins = mm[pc[11:2]];
      if (ins == halt_w) break;
      op  = int'(ins[5:0]);
      rd  = int'(ins[10:6]);
      rs1 = int'(ins[15:11]);
      rs2 = int'(ins[20:16]);
      a = r[rs1]; b = r[rs2]; d = r[rd];
      se = {{16{ins[31]}}, ins[31:16]};
      ze = {16'h0, ins[31:16]};
      npc = pc + 4; wrt = 0; res = 0; cost = 3; ea = a + se;
      case (op)
        ADD:  begin res = a + b; wrt = 1; end
        SUB:  begin res = a - b; wrt = 1; end
        AND_: begin res = a & b; wrt = 1; end
        OR_:  begin res = a | b; wrt = 1; end
        XOR_: begin res = a ^ b; wrt = 1; end
        SHL:  begin res = a << b[4:0]; wrt = 1; end
        SHR:  begin res = a >> b[4:0]; wrt = 1; end
        ADDI: begin res = a + se; wrt = 1; end
        MOVH: begin res = ze << 16; wrt = 1; end
        ORI:  begin res = a | ze; wrt = 1; end
        LD: begin
          res = mm[ea[11:2]]; wrt = 1; cost = 5;
        end
        ST: begin
          cost = 4;
          if (ea[1:0] == 0 && ea < 32'h1000) mm[ea[11:2]] = d;
          if (ea == 0) begin
            exp_d.push_back(d);
            exp_c.push_back(end_cyc + 3);
          end
        end
        BEQ: if (d == a) npc = pc + 4 + (se << 2);
        BNE: if (d != a) npc = pc + 4 + (se << 2);
        JMPL: begin res = pc + 4; npc = a + se; wrt = 1; end
        MUL: begin
`ifdef CPU_MUL_EN
          res = a * b; wrt = 1;
`endif
        end
        default: ;
      endcase
      if (wrt && rd != 0) r[rd] = res;
      pc = npc;
      end_cyc += cost;
    end
  endtask

  task automatic test_reset();
    reset = 1;
    @(posedge clk);
    #1;
    n_chk++;
    if (write !== 1'b0) $display("FAIL reset_write got %b want 0", write);
    else n_pass++;
    n_chk++;
    if (address !== 32'h0) $display("FAIL reset_addr got %h want 0", address);
    else n_pass++;
    n_chk++;
    if (data_out !== 32'h0) $display("FAIL reset_dout got %h want 0", data_out);
    else n_pass++;
  endtask

  task automatic test_alu_store();
    clear_prog();
    emit(enc_i(ADDI, 1, 0, 16'd5));
    emit(enc_i(ADDI, 2, 0, 16'hFFFD));
    emit(enc_r(ADD, 3, 1, 2));
    emit(enc_i(ST, 3, 0, 16'h0));
    emit(halt_w);
    run(24);
    n_chk++;
    if (addr_log[0] !== 32'h0) $display("FAIL first_fetch got %h want 0", addr_log[0]);
    else n_pass++;
    n_chk++;
    if (nwr !== 1) $display("FAIL alu_nwrites got %0d want 1", nwr);
    else n_pass++;
    n_chk++;
    if (got_d.size() != 1 || got_d[0] !== 32'd2)
      $display("FAIL alu_store got %0d stores want 1 of 2", got_d.size());
    else n_pass++;
    n_chk++;
    if (got_c.size() != 1 || got_c[0] != 12)
      $display("FAIL alu_timing got %0d stores want write at cycle 12", got_c.size());
    else n_pass++;
  endtask

  task automatic test_load();
    clear_prog();
    emit(enc_i(MOVH, 1, 0, 16'h1234));
    emit(enc_i(ORI, 1, 1, 16'h5678));
    emit(enc_i(ST, 1, 0, 16'h0100));
    emit(enc_i(LD, 2, 0, 16'h0100));
    emit(enc_i(ST, 2, 0, 16'h0000));
    emit(halt_w);
    run(26);
    n_chk++;
    if (got_d.size() != 1 || got_d[0] !== 32'h12345678)
      $display("FAIL ld_data got %0d stores want one of 12345678", got_d.size());
    else n_pass++;
    n_chk++;
    if (got_c.size() != 1 || got_c[0] != 18)
      $display("FAIL ld_cycles got %0d stores want write at cycle 18", got_c.size());
    else n_pass++;
    n_chk++;
    if (addr_log[13] !== 32'h100) $display("FAIL ld_mem_addr got %h want 100", addr_log[13]);
    else n_pass++;
    n_chk++;
    if (addr_log[15] !== 32'h10) $display("FAIL ld_next_fetch got %h want 10", addr_log[15]);
    else n_pass++;
  endtask

  task automatic test_countdown();
    clear_prog();
    emit(enc_i(ADDI, 1, 0, 16'd3));
    emit(enc_i(ADDI, 1, 1, 16'hFFFF));
    emit(enc_i(BNE, 1, 0, 16'hFFFE));
    emit(enc_i(ST, 1, 0, 16'h0));
    emit(halt_w);
    run(32);
    n_chk++;
    if (got_d.size() != 1 || got_d[0] !== 32'h0)
      $display("FAIL loop_store got %0d stores want one of 0", got_d.size());
    else n_pass++;
    n_chk++;
    if (got_c.size() != 1 || got_c[0] != 24)
      $display("FAIL loop_iters got %0d stores want write at cycle 24", got_c.size());
    else n_pass++;
  endtask

  task automatic test_jmpl();
    clear_prog();
    for (int i = 0; i < 8; i++) emit(32'h0);
    emit(enc_i(JMPL, 5, 0, 16'h0040));
    pp = 16;
    emit(enc_i(ADDI, 0, 0, 16'd7));
    emit(enc_i(ST, 5, 0, 16'h0));
    emit(enc_i(ST, 0, 0, 16'h0));
    emit(halt_w);
    run(44);
    n_chk++;
    if (addr_log[27] !== 32'h40) $display("FAIL jmpl_target got %h want 40", addr_log[27]);
    else n_pass++;
    n_chk++;
    if (got_d.size() != 2) $display("FAIL jmpl_nstores got %0d want 2", got_d.size());
    else n_pass++;
    if (got_d.size() == 2) begin
      n_chk++;
      if (got_d[0] !== 32'h24) $display("FAIL jmpl_link got %h want 24", got_d[0]);
      else n_pass++;
      n_chk++;
      if (got_d[1] !== 32'h0) $display("FAIL r0_write got %h want 0", got_d[1]);
      else n_pass++;
      n_chk++;
      if (got_c[0] != 33 || got_c[1] != 37)
        $display("FAIL jmpl_timing got %0d,%0d want 33,37", got_c[0], got_c[1]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    clear_prog();
    emit(enc_i(ADDI, 1, 0, 16'd9));
    emit(enc_i(ST, 1, 0, 16'h0));
    emit(halt_w);
    reset = 1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 0;
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (write) seen = 1;
    end
    n_chk++;
    if (!seen) $display("FAIL mid_no_store got none want write within 30 cycles");
    else n_pass++;
    #1 reset = 1;
    #1;
    n_chk++;
    if (write !== 1'b0) $display("FAIL mid_write_drop got %b want 0", write);
    else n_pass++;
    n_chk++;
    if (address !== 32'h0) $display("FAIL mid_addr got %h want 0", address);
    else n_pass++;
    n_chk++;
    if (data_out !== 32'h0) $display("FAIL mid_dout got %h want 0", data_out);
    else n_pass++;
    clear_prog();
    emit(enc_i(ST, 1, 0, 16'h0));
    emit(halt_w);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 0;
    repeat (10) @(negedge clk);
    #1;
    n_chk++;
    if (got_d.size() != 1 || got_d[0] !== 32'h0 || got_c[0] != 3)
      $display("FAIL mid_gpr_clear got %0d stores want one of 0 at cycle 3", got_d.size());
    else n_pass++;
  endtask

  task automatic test_mul();
    logic [31:0] want;
`ifdef CPU_MUL_EN
    want = 32'd42;
`else
    want = 32'd0;
`endif
    clear_prog();
    emit(enc_i(ADDI, 1, 0, 16'd6));
    emit(enc_i(ADDI, 2, 0, 16'd7));
    emit(enc_r(MUL, 3, 1, 2));
    emit(enc_i(ST, 3, 0, 16'h0));
    emit(halt_w);
    run(24);
    n_chk++;
    if (got_d.size() != 1 || got_d[0] !== want || got_c[0] != 12)
      $display("FAIL mul got %0d stores want one of %0d at cycle 12", got_d.size(), want);
    else n_pass++;
  endtask

  task automatic test_random();
    int ops [14] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 16, 0, 42, 63};
    int op, rd, ra, rb, k;
    for (int it = 0; it < 5; it++) begin
      clear_prog();
      for (int r = 1; r < 8; r++) begin
        emit(enc_i(MOVH, r, 0, 16'($urandom)));
        emit(enc_i(ORI, r, r, 16'($urandom)));
      end
      for (int n = 0; n < 24; n++) begin
        k  = $urandom_range(0, 9);
        rd = $urandom_range(0, 7);
        ra = $urandom_range(0, 7);
        rb = $urandom_range(0, 7);
        if (k <= 5) begin
          op = ops[$urandom_range(0, 13)];
          if (op inside {1, 2, 3, 4, 5, 6, 7, 16})
            emit(enc_r(op, rd, ra, rb));
          else
            emit(enc_i(op, rd, ra, 16'($urandom)));
          emit(enc_i(ST, rd, 0, 16'h0));
        end else if (k <= 7) begin
          emit(enc_i(ST, ra, 0, 16'h0200));
          emit(enc_i(LD, rd, 0, 16'h0200));
          emit(enc_i(ST, rd, 0, 16'h0));
        end else if (k == 8) begin
          emit(enc_i(($urandom_range(0, 1) == 1) ? BEQ : BNE, rd, ra, 16'd1));
          emit(enc_i(ADDI, 7, 7, 16'd1));
          emit(enc_i(ST, 7, 0, 16'h0));
        end else begin
          emit(enc_i(JMPL, rd, 0, 16'((pp + 2) * 4)));
          emit(enc_i(ADDI, 6, 6, 16'd5));
          emit(enc_i(ST, rd, 0, 16'h0));
          emit(enc_i(ST, 6, 0, 16'h0));
        end
      end
      emit(halt_w);
      iss();
      run(end_cyc + 6);
      n_chk++;
      if (got_d.size() != exp_d.size())
        $display("FAIL rand%0d_count got %0d want %0d", it, got_d.size(), exp_d.size());
      else n_pass++;
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
        n_chk++;
        if (got_d[i] !== exp_d[i] || got_c[i] != exp_c[i])
          $display("FAIL rand%0d_store%0d got %h@%0d want %h@%0d",
                   it, i, got_d[i], got_c[i], exp_d[i], exp_c[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_store();
    test_load();
    test_countdown();
    test_jmpl();
    test_reset_mid();
    test_mul();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
